// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtracter: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtracter.sv
// One-bit full subtracter: d = a - b - bin, built from two half
// subtracters whose borrows are merged with an OR gate.
module full_subtracter (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d_ab;
    logic bout_ab;
    logic bout_bin;

    // First stage subtracts b from a.
    half_subtracter u_hs_ab (
        .a    (a),
        .b    (b),
        .d    (d_ab),
        .bout (bout_ab)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtracter u_hs_bin (
        .a    (d_ab),
        .b    (bin),
        .d    (d),
        .bout (bout_bin)
    );

    // At most one stage can borrow, so OR-ing them gives the outgoing borrow.
    assign bout = bout_ab | bout_bin;

endmodule

// File: rtl/half_subtracter.sv
// One-bit half subtracter: d = a - b, bout set when b exceeds a.
module half_subtracter (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtracter.sv
// Bit-serial unsigned subtracter: computes diff = a - b (mod 2^WIDTH) one
// bit per clock, LSB first, through a single full subtracter stage.
// The result and final borrow are published only when an operation
// completes, so partial results never appear on the outputs.
module serial_subtracter
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Wide enough to hold WIDTH itself, so the count never wraps mid-operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;       // upper bits of the partial result
    logic [WIDTH-1:0] res_next;    // partial result including this cycle's bit
    logic             bor_q;
    logic [CW-1:0]    count_q;
    logic             d_bit;
    logic             bor_next;
    logic             last_bit;

    // The single per-bit datapath stage, fed by the operand LSBs.
    full_subtracter u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (d_bit),
        .bout (bor_next)
    );

    assign last_bit = (count_q == LAST_COUNT);
    assign res_next = {d_bit, res_q};
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH cycles, one DONE cycle.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial shifting, and result publication.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the operand and result registers are reset as well, so an
        // aborted operation leaves no stale data behind.
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            bor_q      <= 1'b0;
            count_q    <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        bor_q   <= 1'b0;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_next[WIDTH-1:1];
                    bor_q   <= bor_next;
                    count_q <= count_q + CW'(1);
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= bor_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtracter.sv
// Self-checking bench for serial_subtracter: an 8-bit instance for the
// directed scenarios and a 4-bit instance for the exhaustive sweep.
// A transaction-level model predicts busy/done/diff/borrow_out on every cycle.
module tb_serial_subtracter;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] diff8;
    logic          borrow8;
    logic          start4 = 1'b0;
    logic [W4-1:0] a4 = '0;
    logic [W4-1:0] b4 = '0;
    logic          busy4;
    logic          done4;
    logic [W4-1:0] diff4;
    logic          borrow4;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtracter #(.WIDTH(W8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8)
    );

    serial_subtracter #(.WIDTH(W4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start opens a WIDTH+1 cycle window (WIDTH busy
    // cycles then one done cycle); the answer is plain modular subtraction.
    int            rem8 = 0;
    logic [W8-1:0] ma8 = '0, mb8 = '0, ed8 = '0;
    logic          eb8 = 1'b0;
    int            rem4 = 0;
    logic [W4-1:0] ma4 = '0, mb4 = '0, ed4 = '0;
    logic          eb4 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem8 <= 0; ed8 <= '0; eb8 <= 1'b0;
        end else if (rem8 > 0) begin
            rem8 <= rem8 - 1;
            if (rem8 == 2) begin
                ed8 <= ma8 - mb8;
                eb8 <= (ma8 < mb8);
            end
        end else if (start8) begin
            rem8 <= W8 + 1;
            ma8  <= a8;
            mb8  <= b8;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem4 <= 0; ed4 <= '0; eb4 <= 1'b0;
        end else if (rem4 > 0) begin
            rem4 <= rem4 - 1;
            if (rem4 == 2) begin
                ed4 <= ma4 - mb4;
                eb4 <= (ma4 < mb4);
            end
        end else if (start4) begin
            rem4 <= W4 + 1;
            ma4  <= a4;
            mb4  <= b4;
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-period.
    always @(negedge clk) begin
        if (check_en) begin
            check("busy8",   busy8,   rem8 >= 2);
            check("done8",   done8,   rem8 == 1);
            check("diff8",   diff8,   ed8);
            check("borrow8", borrow8, eb8);
            check("busy4",   busy4,   rem4 >= 2);
            check("done4",   done4,   rem4 == 1);
            check("diff4",   diff4,   ed4);
            check("borrow4", borrow4, eb4);
        end
    end

    // One 8-bit operation with literal expectations; operands are scrambled
    // right after capture to show they no longer matter.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                        input logic eb, input string nm);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        a8 = ta; b8 = tb_; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_;
        cycles = 1;
        busy_cnt = 0;
        while (!done8 && cycles < 40) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({nm, "_latency"}, cycles, W8 + 1);
        check({nm, "_busy_cycles"}, busy_cnt, W8);
        check({nm, "_diff"}, diff8, ed);
        check({nm, "_borrow"}, borrow8, eb);
        @(negedge clk);
        check({nm, "_done_one_cycle"}, done8, 1'b0);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_);
        int cycles;
        logic [3:0] ed;
        ed = 4'(ta - tb_);
        @(negedge clk);
        a4 = ta; b4 = tb_; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cycles = 1;
        while (!done4 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("sweep_latency", cycles, W4 + 1);
        check("sweep_diff", diff4, ed);
        check("sweep_borrow", borrow4, ta < tb_);
    endtask

    initial begin
        int dones;

        // Reset state.
        #3 rst = 1'b1;
        #1;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_diff", diff8, 8'h00);
        check("rst_borrow", borrow8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        // Directed vectors.
        run8(8'h5A, 8'h3C, 8'h1E, 1'b0, "5a_3c");
        run8(8'h00, 8'h01, 8'hFF, 1'b1, "00_01");
        run8(8'hFF, 8'hFF, 8'h00, 1'b0, "ff_ff");
        run8(8'h80, 8'h7F, 8'h01, 1'b0, "80_7f");

        // start re-pulsed during the fourth SHIFT cycle is ignored.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        repeat (20) begin
            if (done8) dones++;
            @(negedge clk);
        end
        check("repulse_done_count", dones, 1);
        check("repulse_diff", diff8, 8'h1E);

        // Reset in the fifth SHIFT cycle aborts the operation.
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_diff", diff8, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            if (done8) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        check("abort_diff_held", diff8, 8'h00);
        run8(8'h10, 8'h01, 8'h0F, 1'b0, "10_01");

        // start held high: captures at 10-cycle spacing, two within the window.
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) dones++;
        end
        start8 = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("b2b_done_count", dones, 2);
        check("b2b_diff", diff8, 8'h22);

        // Exhaustive 4-bit sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j));
            end
        end

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
